prog_run_ctrl: RTL and testbench
================================

Name: prog_run_ctrl

Overview:
Host-side run controller that drives the processor core's start/halt pair from the opposite end. It preloads data memory from a host byte stream, then pulses the core's start line and times the run until halt. After halt it reads back a fixed window of data memory as a result stream. It is used in the harness wrapping the processor and also provides a hardware cycle count and a timeout watchdog.

Parameters:
START_CYCLES, 2, number of cycles `dut_start` is held high (1..15)
MAX_CYCLES, 16'd60000, watchdog limit on run cycles
RES_BASE, 8'd0, first data-memory address read back after halt
RES_LEN, 8'd64, number of result bytes read back (1..255)

Ports:
CLK  in  1  clock, posedge only
init  in  1  synchronous active-high reset
go  in  1  run request, sampled in IDLE/DONE
ld_valid  in  1  preload byte valid
ld_ready  out  1  preload byte accepted when ld_valid&ld_ready
ld_addr  in  8  preload data-memory address
ld_data  in  8  preload byte
ld_last  in  1  final preload byte
mem_we  out  1  data-memory write enable
mem_addr  out  8  data-memory address, shared between write and read
mem_wdata  out  8  data-memory write data
mem_rdata  in  8  data-memory read data, combinational from mem_addr
dut_start  out  1  core init/reset, active high
dut_halt  in  1  core done flag
res_valid  out  1  result byte valid
res_ready  in  1  result consumer ready
res_addr  out  8  address of result byte
res_data  out  8  result byte
busy  out  1  high in any state except IDLE/DONE
done  out  1  run finished, held until next go
timeout  out  1  watchdog fired on last run, held until next go
cycle_ct  out  16  core cycles counted for last run

Behaviour:
- Reset (init=1 at posedge) values: state=IDLE, dut_start=1 (core held in reset), all other outputs 0, cycle_ct=0. init overrides everything, including a run in progress. No memory write occurs in the reset cycle.
- IDLE: ld_ready=0. On go=1, go to LOAD and clear done, timeout and cycle_ct.
- DONE: ld_ready=0. On go=1, go to LOAD and clear done, timeout and cycle_ct.
- LOAD: ld_ready=1.
  - Each accepted byte drives mem_we=1, mem_addr=ld_addr and mem_wdata=ld_data combinationally in the same cycle.
  - Duplicate addresses are allowed; the last write wins.
  - An accepted byte with ld_last=1 moves the FSM to START.
  - No data beats are accepted outside LOAD. A zero-length preload is the host sending one byte with ld_last=1.
- START: dut_start=1 for exactly START_CYCLES cycles, counted by an internal counter, then RUN. mem_we=0.
- RUN:
  - dut_start=0.
  - cycle_ct increments by 1 each cycle in which dut_halt=0.
  - dut_halt=1 sampled: go to DRAIN; cycle_ct is frozen.
  - cycle_ct reaches MAX_CYCLES with dut_halt still 0: timeout=1, then DONE. No readback occurs.
  - If halt and the limit coincide in the same cycle, halt wins: timeout=0 and the FSM goes to DRAIN.
- DRAIN:
  - dut_start is re-asserted to 1, freezing the core.
  - Output index i runs 0..RES_LEN-1. mem_addr=RES_BASE+i with 8-bit wraparound; res_addr=mem_addr; res_data=mem_rdata; res_valid=1.
  - i advances only on res_valid&res_ready. While res_ready=0, res_data/res_addr are held stable.
  - After the handshake on i=RES_LEN-1: done=1, then DONE.
- DONE: dut_start=1 (core held in reset). done=1 is held. busy=0.
- ld_ready is asserted only in LOAD. res_valid is asserted only in DRAIN. mem_we is asserted only in LOAD on a handshake.
- go while busy is ignored.

Test Plan:
- Reset then idle: init=1 for 2 cycles, go=0 -> dut_start=1; busy=0, done=0, timeout=0, ld_ready=0, res_valid=0, cycle_ct=0.
- Preload and normal run:
  - Stimulus: load 3 bytes (addr 0x10/0x11/0x12 = 0xA5/0x5A/0xFF, last on third); core model asserts halt 37 cycles after dut_start falls; RES_BASE=0x10, RES_LEN=3.
  - Required response: exactly 3 mem_we pulses; dut_start high for exactly 2 cycles; cycle_ct=37; res stream carries 0xA5, 0x5A, 0xFF at res_addr 0x10..0x12; then done=1.
- Backpressure: hold res_ready=0 for 5 cycles on byte 1 -> res_data/res_addr stable, no skipped or duplicated bytes, byte order preserved.
- Watchdog: MAX_CYCLES=100, halt never rises -> timeout=1, cycle_ct=100, zero res_valid cycles, done=0, state DONE.
- Halt/limit tie: halt rises on the cycle cycle_ct hits MAX_CYCLES -> timeout=0, readback performed.
- Reset mid-run: init=1 during RUN at cycle 20 -> next cycle state IDLE, dut_start=1, cycle_ct=0, no res_valid; a following go starts a clean run with correct results.

Source files
------------

// File: rtl/prog_run_ctrl.sv
// Host-side run controller: preloads core data memory, pulses the core start line,
// times the run against a watchdog, then streams back a window of data memory.
module prog_run_ctrl #(
    parameter int unsigned START_CYCLES = 2,
    parameter logic [15:0] MAX_CYCLES   = 16'd60000,
    parameter logic [7:0]  RES_BASE     = 8'd0,
    parameter logic [7:0]  RES_LEN      = 8'd64
) (
    input  logic        CLK,
    input  logic        init,
    input  logic        go,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dut_start,
    input  logic        dut_halt,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_addr,
    output logic [7:0]  res_data,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cycle_ct
);

    // state  | meaning
    // IDLE   | after reset, core held in reset, waiting for go
    // LOAD   | accepting preload bytes into data memory
    // START  | core start line held high for START_CYCLES cycles
    // RUN    | core running, cycle counter and watchdog active
    // DRAIN  | core frozen, result window streamed out
    // DONE   | run finished (or timed out), waiting for next go
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] START_LOAD = 4'(START_CYCLES - 1);
    localparam logic [7:0] RES_LAST   = RES_LEN - 8'd1;

    state_t      state_q, state_d;
    logic [3:0]  start_ct_q, start_ct_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] cycle_ct_q, cycle_ct_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    always_ff @(posedge CLK) begin
        if (init) begin
            state_q    <= S_IDLE;
            start_ct_q <= '0;
            idx_q      <= '0;
            cycle_ct_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_ct_q <= start_ct_d;
            idx_q      <= idx_d;
            cycle_ct_q <= cycle_ct_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_ct_d = start_ct_q;
        idx_d      = idx_q;
        cycle_ct_d = cycle_ct_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        ld_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        dut_start  = 1'b1;
        res_valid  = 1'b0;
        res_addr   = '0;
        res_data   = '0;
        busy       = 1'b1;

        case (state_q)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                if (go) begin
                    state_d    = S_LOAD;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    cycle_ct_d = '0;
                end
            end
            S_LOAD: begin
                ld_ready  = 1'b1;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
                mem_we    = ld_valid;
                if (ld_valid && ld_last) begin
                    state_d    = S_START;
                    start_ct_d = START_LOAD;
                end
            end
            S_START: begin
                if (start_ct_q == 4'd0) begin
                    state_d = S_RUN;
                end else begin
                    start_ct_d = start_ct_q - 4'd1;
                end
            end
            S_RUN: begin
                dut_start = 1'b0;
                // halt is checked first so a halt coinciding with the limit still reads back
                if (dut_halt) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else if (cycle_ct_q == MAX_CYCLES) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cycle_ct_d = cycle_ct_q + 16'd1;
                end
            end
            S_DRAIN: begin
                mem_addr  = RES_BASE + idx_q;
                res_valid = 1'b1;
                res_addr  = RES_BASE + idx_q;
                res_data  = mem_rdata;
                if (res_ready) begin
                    if (idx_q == RES_LAST) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // init wins over any in-flight handshake, so no write or beat leaks out in the reset cycle
        if (init) begin
            ld_ready  = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            res_valid = 1'b0;
            res_addr  = '0;
            res_data  = '0;
            dut_start = 1'b1;
            busy      = 1'b0;
        end
    end

    assign done     = done_q;
    assign timeout  = timeout_q;
    assign cycle_ct = cycle_ct_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl with a byte memory and a core model that halts
// a programmable number of cycles after its start line falls.
module tb_prog_run_ctrl;

    logic        CLK = 1'b0;
    logic        init, go, ld_valid, ld_last, res_ready;
    logic        dut_halt = 1'b0;
    logic [7:0]  ld_addr, ld_data, mem_rdata;
    logic        ld_ready, mem_we, dut_start, res_valid, busy, done, timeout;
    logic [7:0]  mem_addr, mem_wdata, res_addr, res_data;
    logic [15:0] cycle_ct;

    logic [7:0]  mem [256];
    int          halt_after = 0;
    int          run_ct = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [7:0]  la [8];
    logic [7:0]  lda [8];
    logic [7:0]  got_a [8];
    logic [7:0]  got_d [8];
    logic [7:0]  hold_a, hold_d;
    int          we_ct, start_hi, rv_cyc, beats, unstable;
    bit          run_tmo;

    always #5 CLK = ~CLK;

    prog_run_ctrl #(
        .START_CYCLES(2),
        .MAX_CYCLES  (16'd100),
        .RES_BASE    (8'h10),
        .RES_LEN     (8'd3)
    ) dut (
        .CLK      (CLK),
        .init     (init),
        .go       (go),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .dut_start(dut_start),
        .dut_halt (dut_halt),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_addr (res_addr),
        .res_data (res_data),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .cycle_ct (cycle_ct)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

    // halt rises after halt_after cycles with start low; halt_after==0 means never
    always @(posedge CLK) begin
        if (dut_start) begin
            run_ct   <= 0;
            dut_halt <= 1'b0;
        end else if (!dut_halt) begin
            run_ct <= run_ct + 1;
            if (halt_after != 0 && run_ct + 1 == halt_after) dut_halt <= 1'b1;
        end
    end

    task automatic load_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            do begin
                @(negedge CLK);
                go = 1'b0; ld_valid = 1'b1; ld_addr = la[i]; ld_data = lda[i]; ld_last = (i == n - 1);
                #1;
                if (mem_we) we_ct++;
                w++;
            end while (!ld_ready && w < 20);
            if (!ld_ready) run_tmo = 1'b1;
        end
    endtask

    task automatic exec_run(input int h, input int n, input int stall_idx, input int stall_len);
        int stall_left = stall_len;
        bit fell = 1'b0;
        halt_after = h;
        we_ct = 0; start_hi = 0; rv_cyc = 0; beats = 0; unstable = 0; run_tmo = 1'b0;
        hold_a = '0; hold_d = '0;
        @(negedge CLK); go = 1'b1;
        load_bytes(n);
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            ld_valid = 1'b0; ld_last = 1'b0;
            res_ready = !(beats == stall_idx && stall_left > 0);
            #1;
            if (mem_we) we_ct++;
            if (!fell) begin
                if (dut_start) start_hi++;
                else fell = 1'b1;
            end
            if (res_valid) begin
                rv_cyc++;
                if (!res_ready) begin
                    if (stall_left == stall_len) begin
                        hold_a = res_addr; hold_d = res_data;
                    end else if (res_addr !== hold_a || res_data !== hold_d) begin
                        unstable++;
                    end
                    stall_left--;
                end else begin
                    if (beats < 8) begin
                        got_a[beats] = res_addr; got_d[beats] = res_data;
                    end
                    beats++;
                end
            end
            if (!busy) break;
        end
        if (busy) run_tmo = 1'b1;
        res_ready = 1'b1;
    endtask

    task automatic test_reset();
        init = 1'b1; go = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0; res_ready = 1'b1;
        @(negedge CLK); @(negedge CLK);
        init = 1'b0;
        #1;
        n_checks++; if (dut_start !== 1'b1) begin n_fail++; $display("FAIL reset_dut_start got %b want 1", dut_start); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_checks++; if (cycle_ct !== 16'd0) begin n_fail++; $display("FAIL reset_cycle_ct got %0d want 0", cycle_ct); end
        // data beats offered while idle must be refused
        @(negedge CLK); ld_valid = 1'b1; ld_addr = 8'h20; ld_data = 8'h99; ld_last = 1'b1;
        #1;
        n_checks++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_no_load got ready=%b we=%b want 0 0", ld_ready, mem_we); end
        @(negedge CLK); ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || dut_start !== 1'b1) begin n_fail++; $display("FAIL idle_stays got busy=%b start=%b want 0 1", busy, dut_start); end
    endtask

    task automatic test_normal_run();
        la[0] = 8'h10; lda[0] = 8'hA5;
        la[1] = 8'h11; lda[1] = 8'h5A;
        la[2] = 8'h12; lda[2] = 8'hFF;
        exec_run(37, 3, -1, 0);
        n_checks++; if (run_tmo !== 1'b0) begin n_fail++; $display("FAIL normal_budget got expired want completed"); end
        n_checks++; if (we_ct !== 3) begin n_fail++; $display("FAIL normal_we_count got %0d want 3", we_ct); end
        n_checks++; if (start_hi !== 2) begin n_fail++; $display("FAIL normal_start_len got %0d want 2", start_hi); end
        n_checks++; if (cycle_ct !== 16'd37) begin n_fail++; $display("FAIL normal_cycle_ct got %0d want 37", cycle_ct); end
        n_checks++; if (beats !== 3 || rv_cyc !== 3) begin n_fail++; $display("FAIL normal_beats got %0d/%0d want 3/3", beats, rv_cyc); end
        n_checks++; if (got_d[0] !== 8'hA5 || got_d[1] !== 8'h5A || got_d[2] !== 8'hFF) begin n_fail++; $display("FAIL normal_data got %h %h %h want a5 5a ff", got_d[0], got_d[1], got_d[2]); end
        n_checks++; if (got_a[0] !== 8'h10 || got_a[1] !== 8'h11 || got_a[2] !== 8'h12) begin n_fail++; $display("FAIL normal_addr got %h %h %h want 10 11 12", got_a[0], got_a[1], got_a[2]); end
        n_checks++; if (done !== 1'b1 || timeout !== 1'b0 || dut_start !== 1'b1) begin n_fail++; $display("FAIL normal_final got done=%b tmo=%b start=%b want 1 0 1", done, timeout, dut_start); end
    endtask

    task automatic test_backpressure();
        la[0] = 8'h12; lda[0] = 8'h77;
        exec_run(10, 1, 1, 5);
        n_checks++; if (run_tmo !== 1'b0) begin n_fail++; $display("FAIL bp_budget got expired want completed"); end
        n_checks++; if (beats !== 3 || rv_cyc !== 8) begin n_fail++; $display("FAIL bp_beats got %0d/%0d want 3/8", beats, rv_cyc); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
        n_checks++; if (hold_a !== 8'h11 || hold_d !== 8'h5A) begin n_fail++; $display("FAIL bp_held got %h/%h want 11/5a", hold_a, hold_d); end
        n_checks++; if (got_d[0] !== 8'hA5 || got_d[1] !== 8'h5A || got_d[2] !== 8'h77) begin n_fail++; $display("FAIL bp_data got %h %h %h want a5 5a 77", got_d[0], got_d[1], got_d[2]); end
        n_checks++; if (got_a[0] !== 8'h10 || got_a[1] !== 8'h11 || got_a[2] !== 8'h12) begin n_fail++; $display("FAIL bp_addr got %h %h %h want 10 11 12", got_a[0], got_a[1], got_a[2]); end
        n_checks++; if (cycle_ct !== 16'd10 || done !== 1'b1) begin n_fail++; $display("FAIL bp_final got ct=%0d done=%b want 10 1", cycle_ct, done); end
    endtask

    task automatic test_watchdog();
        la[0] = 8'h40; lda[0] = 8'hC3;
        exec_run(0, 1, -1, 0);
        n_checks++; if (run_tmo !== 1'b0) begin n_fail++; $display("FAIL wd_budget got expired want completed"); end
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout got %b want 1", timeout); end
        n_checks++; if (cycle_ct !== 16'd100) begin n_fail++; $display("FAIL wd_cycle_ct got %0d want 100", cycle_ct); end
        n_checks++; if (rv_cyc !== 0) begin n_fail++; $display("FAIL wd_no_readback got %0d want 0", rv_cyc); end
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || dut_start !== 1'b1) begin n_fail++; $display("FAIL wd_final got done=%b busy=%b start=%b want 0 0 1", done, busy, dut_start); end
        n_checks++; if (we_ct !== 1 || mem[8'h40] !== 8'hC3) begin n_fail++; $display("FAIL wd_single_load got we=%0d mem=%h want 1 c3", we_ct, mem[8'h40]); end
    endtask

    task automatic test_halt_limit_tie();
        la[0] = 8'h11; lda[0] = 8'h00;
        la[1] = 8'h11; lda[1] = 8'h3C;
        exec_run(100, 2, -1, 0);
        n_checks++; if (run_tmo !== 1'b0) begin n_fail++; $display("FAIL tie_budget got expired want completed"); end
        n_checks++; if (timeout !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL tie_flags got tmo=%b done=%b want 0 1", timeout, done); end
        n_checks++; if (cycle_ct !== 16'd100) begin n_fail++; $display("FAIL tie_cycle_ct got %0d want 100", cycle_ct); end
        n_checks++; if (we_ct !== 2 || beats !== 3) begin n_fail++; $display("FAIL tie_counts got we=%0d beats=%0d want 2 3", we_ct, beats); end
        n_checks++; if (got_d[0] !== 8'hA5 || got_d[1] !== 8'h3C || got_d[2] !== 8'h77) begin n_fail++; $display("FAIL tie_data got %h %h %h want a5 3c 77", got_d[0], got_d[1], got_d[2]); end
    endtask

    task automatic test_reset_mid_run();
        bit hit = 1'b0;
        la[0] = 8'h10; lda[0] = 8'h01;
        la[1] = 8'h11; lda[1] = 8'h02;
        la[2] = 8'h12; lda[2] = 8'h03;
        halt_after = 37;
        @(negedge CLK); go = 1'b1;
        load_bytes(3);
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK); ld_valid = 1'b0; ld_last = 1'b0;
            #1;
            if (cycle_ct == 16'd20) begin hit = 1'b1; break; end
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL mid_reach20 got ct=%0d want 20", cycle_ct); end
        init = 1'b1;
        @(negedge CLK); init = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || dut_start !== 1'b1) begin n_fail++; $display("FAIL mid_idle got busy=%b start=%b want 0 1", busy, dut_start); end
        n_checks++; if (cycle_ct !== 16'd0 || res_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_cleared got ct=%0d rv=%b done=%b want 0 0 0", cycle_ct, res_valid, done); end
        exec_run(15, 3, -1, 0);
        n_checks++; if (run_tmo !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL mid_rerun got tmo=%b done=%b want 0 1", run_tmo, done); end
        n_checks++; if (cycle_ct !== 16'd15) begin n_fail++; $display("FAIL mid_rerun_ct got %0d want 15", cycle_ct); end
        n_checks++; if (got_d[0] !== 8'h01 || got_d[1] !== 8'h02 || got_d[2] !== 8'h03) begin n_fail++; $display("FAIL mid_rerun_data got %h %h %h want 01 02 03", got_d[0], got_d[1], got_d[2]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_normal_run();
        test_backpressure();
        test_watchdog();
        test_halt_limit_tie();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got expired want finished");
        $fatal(1, "time limit");
    end

endmodule
